noc_switch_allocator: RTL and testbench

//  Per-router output-port allocator: shares each of the 5 output ports among the 5 input ports.
//  - Takes the registered one-hot port requests from the 5 per-input LBDR units.
//  - Locks an output to one input from HEADER to TAIL (wormhole); round-robin among competing HEADERs.
//  - Drives input-FIFO read enables and crossbar selects; sits between LBDR/input FIFOs and the crossbar.

---
 rtl/noc_switch_allocator_pkg.sv | 29 ++
 rtl/noc_switch_allocator_rr_arbiter.sv | 32 +++
 rtl/noc_switch_allocator.sv | 123 ++++++++++++
 tb/tb_noc_switch_allocator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_switch_allocator_pkg.sv
// Shared constants and types for the NoC switch allocator.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int IDX_W  = 3;
  localparam int FLIT_W = 3;

  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_W = 2;
  localparam int P_S = 3;
  localparam int P_L = 4;

  // Flit-type codes carried on in_flit_id (one-hot encoded).
  localparam logic [FLIT_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_W-1:0] FLIT_TAIL   = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

  // Port index following i, wrapping from the last port back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NPORTS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Round-robin arbiter: first requester found scanning cyclically from i_ptr.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int N = NPORTS,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx
);

  // Cyclic scan starting at the pointer; the first hit wins.
  always_comb begin
    int  j;
    logic w_found;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[j]) begin
        o_gnt[j] = 1'b1;
        o_idx    = W'(j);
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Per-router output-port allocator with wormhole locking and round-robin
// arbitration among competing HEADER flits.
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          in_valid,
  input  logic [NPORTS*NPORTS-1:0]   in_req,
  input  logic [FLIT_W*NPORTS-1:0]   in_flit_id,
  input  logic [NPORTS-1:0]          out_ready,
  output logic [NPORTS-1:0]          rd_en,
  output logic [NPORTS-1:0]          out_valid,
  output logic [IDX_W*NPORTS-1:0]    xbar_sel,
  output logic [NPORTS-1:0]          out_busy,
  output logic                       err_multi
);

  localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

  logic [NPORTS-1:0]       w_req_eff [NPORTS];
  logic [NPORTS-1:0]       w_multi;
  logic [NPORTS-1:0]       w_cand    [NPORTS];
  logic [NPORTS-1:0]       w_fire;
  logic [IDX_W*NPORTS-1:0] w_owner;
  logic                    r_err_multi;

  // Reduce each input's request to its lowest set bit; flag multi-hot rows.
  always_comb begin
    logic [NPORTS-1:0] w_row;
    w_row   = '0;
    w_multi = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_row        = in_req[i*NPORTS +: NPORTS];
      w_req_eff[i] = w_row & (~w_row + ONE);
      w_multi[i]   = in_valid[i] && ((w_row & (w_row - ONE)) != '0);
    end
  end

  // Transpose into per-output candidate vectors: only HEADER flits compete.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      w_cand[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        w_cand[o][i] = in_valid[i] && w_req_eff[i][o] &&
                       (in_flit_id[i*FLIT_W +: FLIT_W] == FLIT_HEADER);
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    alloc_state_t      r_state;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_ptr;
    logic [NPORTS-1:0] w_gnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_tail;

    rr_arbiter #(.N(NPORTS), .W(IDX_W)) u_arb (
      .i_req (w_cand[o]),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
    );

    assign w_fire[o] = (r_state == BUSY) && in_valid[r_owner] && out_ready[o];
    assign w_tail    = (in_flit_id[r_owner*FLIT_W +: FLIT_W] == FLIT_TAIL);

    // Output lock FSM: grant in IDLE, release after the TAIL flit crosses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= IDLE;
        r_owner <= '0;
        r_ptr   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (|w_gnt) begin
              r_state <= BUSY;
              r_owner <= w_idx;
              r_ptr   <= next_idx(w_idx);
            end
          end
          BUSY: begin
            if (w_fire[o] && w_tail) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end

    assign w_owner[o*IDX_W +: IDX_W]  = r_owner;
    assign xbar_sel[o*IDX_W +: IDX_W] = (r_state == BUSY) ? r_owner : '0;
    assign out_busy[o]                = (r_state == BUSY);
    assign out_valid[o]               = w_fire[o];
  end

  // Pop the owning input of every output that moves a flit this cycle.
  always_comb begin
    rd_en = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_fire[o] && (w_owner[o*IDX_W +: IDX_W] == IDX_W'(i))) begin
          rd_en[i] = 1'b1;
        end
      end
    end
  end

  // Sticky multi-hot request flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_multi <= 1'b0;
    end else if (|w_multi) begin
      r_err_multi <= 1'b1;
    end
  end

  assign err_multi = r_err_multi;

endmodule

// File: tb/tb_noc_switch_allocator.sv
module tb_noc_switch_allocator;
  import noc_pkg::*;

  typedef struct packed {
    logic [4:0] req;
    logic [2:0] id;
  } flit_t;

  logic        clk;
  logic        rst;
  logic [4:0]  in_valid;
  logic [24:0] in_req;
  logic [14:0] in_flit_id;
  logic [4:0]  out_ready;
  logic [4:0]  rd_en;
  logic [4:0]  out_valid;
  logic [14:0] xbar_sel;
  logic [4:0]  out_busy;
  logic        err_multi;

  noc_switch_allocator dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_req     (in_req),
    .in_flit_id (in_flit_id),
    .out_ready  (out_ready),
    .rd_en      (rd_en),
    .out_valid  (out_valid),
    .xbar_sel   (xbar_sel),
    .out_busy   (out_busy),
    .err_multi  (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream input FIFOs and reference-model state.
  flit_t q [5][$];
  int    m_own [5];   // -1 = output free, else owning input
  int    m_rr  [5];
  bit    m_err;
  int    n_cmp;
  int    n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [4:0] r);
    for (int o = 0; o < 5; o++) if (r[o]) return o;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      if (q[i].size() > 0) begin
        in_valid[i]         = 1'b1;
        in_req[i*5 +: 5]     = q[i][0].req;
        in_flit_id[i*3 +: 3] = q[i][0].id;
      end else begin
        in_valid[i]         = 1'b0;
        in_req[i*5 +: 5]     = 5'b0;
        in_flit_id[i*3 +: 3] = 3'b0;
      end
    end
  endtask

  task automatic push_pkt(input int src, input logic [4:0] r, input int nbody);
    flit_t f;
    f.req = r;
    f.id  = FLIT_HEADER;
    q[src].push_back(f);
    for (int b = 0; b < nbody; b++) begin
      f.id = FLIT_BODY;
      q[src].push_back(f);
    end
    f.id = FLIT_TAIL;
    q[src].push_back(f);
    drive();
  endtask

  // One clock: compare against the model at negedge, advance it at posedge.
  task automatic tick();
    logic [4:0]  eb, ev, er;
    logic [14:0] es;
    int          n_own [5];
    int          n_rr  [5];
    bit          ne;
    bit          found;
    int          i;
    @(negedge clk);
    eb = '0; ev = '0; er = '0; es = '0; ne = m_err;
    for (int o = 0; o < 5; o++) begin
      n_own[o] = m_own[o];
      n_rr[o]  = m_rr[o];
      if (m_own[o] >= 0) begin
        i = m_own[o];
        eb[o] = 1'b1;
        es[o*3 +: 3] = 3'(i);
        if (q[i].size() > 0 && out_ready[o]) begin
          ev[o] = 1'b1;
          er[i] = 1'b1;
          if (q[i][0].id == FLIT_TAIL) n_own[o] = -1;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          i = (m_rr[o] + k) % 5;
          if (!found && q[i].size() > 0 && lowest(q[i][0].req) == o &&
              q[i][0].id == FLIT_HEADER) begin
            found    = 1'b1;
            n_own[o] = i;
            n_rr[o]  = (i + 1) % 5;
          end
        end
      end
    end
    for (int s = 0; s < 5; s++)
      if (q[s].size() > 0 && $countones(q[s][0].req) > 1) ne = 1'b1;
    chk("out_busy",  32'(out_busy),  32'(eb));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("rd_en",     32'(rd_en),     32'(er));
    chk("xbar_sel",  32'(xbar_sel),  32'(es));
    chk("err_multi", 32'(err_multi), 32'(m_err));
    @(posedge clk);
    #1;
    for (int o = 0; o < 5; o++) begin
      m_own[o] = n_own[o];
      m_rr[o]  = n_rr[o];
    end
    m_err = ne;
    for (int s = 0; s < 5; s++) if (er[s]) void'(q[s].pop_front());
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) q[i].delete();
    drive();
    #1;
    chk("rst_busy",  32'(out_busy),  32'd0);
    chk("rst_rd_en", 32'(rd_en),     32'd0);
    chk("rst_oval",  32'(out_valid), 32'd0);
    chk("rst_sel",   32'(xbar_sel),  32'd0);
    chk("rst_err",   32'(err_multi), 32'd0);
    for (int o = 0; o < 5; o++) begin
      m_own[o] = -1;
      m_rr[o]  = 0;
    end
    m_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      n += q[i].size();
      if (m_own[i] >= 0) n++;
    end
    return n;
  endfunction

  task automatic drain(input int limit);
    int c = 0;
    out_ready = 5'b11111;
    while (outstanding() > 0 && c < limit) begin
      tick();
      c++;
    end
    chk("drain_left", 32'(outstanding()), 32'd0);
  endtask

  initial begin
    int          src, dst;
    logic [4:0]  r;
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b0;
    in_valid   = '0;
    in_req     = '0;
    in_flit_id = '0;
    out_ready  = 5'b11111;
    #2;

    // 1: single packet E -> L
    do_reset();
    push_pkt(P_E, 5'b10000, 1);
    tick();
    chk("t1_busy_L", 32'(out_busy[P_L]), 32'd1);
    chk("t1_sel_L",  32'(xbar_sel[P_L*3 +: 3]), 32'd1);
    chk("t1_rd_E",   32'(rd_en[P_E]), 32'd1);
    tick(); tick(); tick();
    chk("t1_free_L", 32'(out_busy[P_L]), 32'd0);

    // 2: N and W contend for S; N first, W after one bubble
    do_reset();
    push_pkt(P_N, 5'b01000, 0);
    push_pkt(P_W, 5'b01000, 0);
    tick();
    chk("t2_busy_S",  32'(out_busy[P_S]), 32'd1);
    chk("t2_owner_N", 32'(xbar_sel[P_S*3 +: 3]), 32'd0);
    tick(); tick();
    chk("t2_bubble",  32'(out_busy[P_S]), 32'd0);
    tick();
    chk("t2_owner_W", 32'(xbar_sel[P_S*3 +: 3]), 32'd2);
    drain(50);
    do_reset();
    push_pkt(P_N, 5'b01000, 0);
    drain(50);
    push_pkt(P_N, 5'b01000, 0);
    push_pkt(P_W, 5'b01000, 0);
    tick();
    chk("t2_w_first", 32'(xbar_sel[P_S*3 +: 3]), 32'd2);
    drain(50);

    // 3: lock held while out_ready[E] is low
    do_reset();
    out_ready = 5'b11101;
    push_pkt(P_N, 5'b00010, 1);
    push_pkt(P_S, 5'b00010, 0);
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("t3_rd_en", 32'(rd_en), 32'd0);
      chk("t3_oval",  32'(out_valid), 32'd0);
      tick();
    end
    chk("t3_busy_E",  32'(out_busy[P_E]), 32'd1);
    chk("t3_owner_N", 32'(xbar_sel[P_E*3 +: 3]), 32'd0);
    drain(50);

    // 4: independent outputs grant together
    do_reset();
    push_pkt(P_N, 5'b00010, 2);
    push_pkt(P_S, 5'b00100, 1);
    tick();
    chk("t4_busy", 32'(out_busy), 32'b00110);
    drain(50);

    // 5: multi-hot request from L
    do_reset();
    push_pkt(P_L, 5'b00110, 1);
    tick();
    chk("t5_busy_E", 32'(out_busy[P_E]), 32'd1);
    chk("t5_sel_E",  32'(xbar_sel[P_E*3 +: 3]), 32'd4);
    tick();
    chk("t5_err", 32'(err_multi), 32'd1);
    drain(50);
    chk("t5_err_sticky", 32'(err_multi), 32'd1);

    // zero request and stray BODY are never granted
    do_reset();
    begin
      flit_t f;
      f.req = 5'b00010; f.id = FLIT_BODY;
      q[P_N].push_back(f);
      f.req = 5'b00000; f.id = FLIT_HEADER;
      q[P_E].push_back(f);
      drive();
    end
    for (int c = 0; c < 4; c++) tick();
    chk("ignored_busy", 32'(out_busy), 32'd0);

    // 6: reset mid-packet, then a fresh packet
    do_reset();
    push_pkt(P_N, 5'b01000, 2);
    tick(); tick(); tick();
    chk("t6_pre_busy", 32'(out_busy[P_S]), 32'd1);
    do_reset();
    push_pkt(P_W, 5'b10000, 0);
    tick();
    chk("t6_regrant", 32'(out_busy[P_L]), 32'd1);
    drain(50);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        src = $urandom_range(0, 4);
        dst = $urandom_range(0, 4);
        r   = 5'(1 << dst);
        if (dst < 4 && $urandom_range(0, 9) == 0) r = r | 5'(1 << $urandom_range(dst + 1, 4));
        if (q[src].size() < 10) push_pkt(src, r, $urandom_range(0, 3));
      end
      out_ready = 5'($urandom) | 5'($urandom);
      drive();
      tick();
    end
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
